// File: rtl/isqrt_seq.sv
// Sequential integer square root: one root bit per clock, valid/ready on both sides.
// Define ISQRT_ROUND_EN to report round-to-nearest root instead of floor.
module isqrt_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH/2-1:0]   out_root,
   output logic [WIDTH/2:0]     out_rem,
   output logic                 busy
);
   localparam int RW = WIDTH / 2;
   localparam int CW = (RW > 1) ? $clog2(RW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] rad_q, rad_d;
   logic [RW-1:0]   root_q, root_d;
   logic [RW+1:0]   rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   oroot_q, oroot_d;
   logic [RW:0]     orem_q, orem_d;

   logic [RW+1:0]   rem_sh, trial, rem_it;
   logic [RW-1:0]   root_it, fin_root;
   logic            ge, last;

   always_comb begin
      rem_sh  = (rem_q << 2) | {{RW{1'b0}}, rad_q[WIDTH-1 -: 2]};
      trial   = {root_q, 2'b01};
      ge      = (rem_sh >= trial);
      rem_it  = ge ? (rem_sh - trial) : rem_sh;
      root_it = (root_q << 1) | {{(RW-1){1'b0}}, ge};
      last    = (cnt_q == CW'(RW-1));
`ifdef ISQRT_ROUND_EN
      // rem > root means x is past (root+0.5)^2; saturate instead of wrapping
      fin_root = ((rem_it[RW:0] > {1'b0, root_it}) && !(&root_it)) ? root_it + 1'b1 : root_it;
`else
      fin_root = root_it;
`endif
   end

   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      root_d  = root_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      oroot_d = oroot_q;
      orem_d  = orem_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rad_d   = in_data;
               root_d  = '0;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            rad_d  = rad_q << 2;
            root_d = root_it;
            rem_d  = rem_it;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               oroot_d = fin_root;
               orem_d  = rem_it[RW:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rad_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         oroot_q <= '0;
         orem_q  <= '0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         oroot_q <= oroot_d;
         orem_q  <= orem_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_root  = oroot_q;
   assign out_rem   = orem_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// Directed + reference-model checks for isqrt_seq (WIDTH=32); honours ISQRT_ROUND_EN.
module tb_isqrt_seq;
   localparam int WIDTH = 32;
   localparam int RW    = WIDTH / 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [RW-1:0]     out_root;
   logic [RW:0]       out_rem;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   isqrt_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_root(out_root), .out_rem(out_rem), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Bit-by-bit greedy search, independent of the hardware recurrence
   function automatic logic [RW-1:0] ref_root(input logic [WIDTH-1:0] x);
      logic [RW-1:0] r, t;
      longint unsigned sq;
      r = '0;
      for (int b = RW-1; b >= 0; b--) begin
         t  = r | (RW'(1) << b);
         sq = longint'(t) * longint'(t);
         if (sq <= longint'(x)) r = t;
      end
      return r;
   endfunction

   task automatic do_op(input logic [WIDTH-1:0] x, input logic [RW-1:0] er_floor,
                        input logic [RW-1:0] er_round, input logic [RW:0] em, input int hold);
      int n;
      logic [RW-1:0] er;
      logic          rdy_seen;
`ifdef ISQRT_ROUND_EN
      er = er_round;
`else
      er = er_floor;
`endif
      @(negedge clk);
      in_data  = x;
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      n = 0;
      rdy_seen = 1'b0;
      while (!out_valid && n < 40) begin
         if (in_ready || !busy) rdy_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      check("latency", n, RW);
      check("in_ready_low_calc", rdy_seen, 0);
      if (!out_valid) return;
      check("root", out_root, er);
      check("rem", out_rem, em);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_root", out_root, er);
         check("hold_rem", out_rem, em);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   initial begin
      int seen;
      logic [WIDTH-1:0] x;
      logic [RW-1:0]    r, rr;
      logic [RW:0]      m;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_root", out_root, 0);
      check("rst_rem", out_rem, 0);
      rst_n = 1'b1;

      //        x             floor       round       rem       hold
      do_op(32'd0,          16'd0,      16'd0,      17'd0,      0);
      do_op(32'd144,        16'd12,     16'd12,     17'd0,      0);
      do_op(32'd99,         16'd9,      16'd10,     17'd18,     0);
      do_op(32'hFFFFFFFF,   16'hFFFF,   16'hFFFF,   17'h1FFFE,  0);
      do_op(32'd2,          16'd1,      16'd1,      17'd1,      0);
      do_op(32'd3,          16'd1,      16'd2,      17'd2,      0);
      do_op(32'd15,         16'd3,      16'd4,      17'd6,      0);
      do_op(32'hFFFE0001,   16'hFFFF,   16'hFFFF,   17'd0,      0);
      do_op(32'h40000000,   16'd32768,  16'd32768,  17'd0,      0);

      // backpressure: hold the result for 10 cycles
      @(negedge clk);
      out_ready = 1'b0;
      do_op(32'd1000000,    16'd1000,   16'd1000,   17'd0,      10);

      // reset in the middle of CALC
      @(negedge clk);
      in_data  = 32'd12345;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("midcalc_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_root", out_root, 0);
      check("midrst_rem", out_rem, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_valid_after_rst", seen, 0);
      do_op(32'd90,         16'd9,      16'd9,      17'd9,      0);

      // random back-to-back against the reference search
      for (int k = 0; k < 2000; k++) begin
         x  = $urandom;
         if (k % 4 == 0) x = x >> ($urandom_range(31, 0));
         r  = ref_root(x);
         m  = (RW+1)'(longint'(x) - longint'(r) * longint'(r));
         rr = ((m > {1'b0, r}) && (r != '1)) ? r + 1'b1 : r;
         do_op(x, r, rr, m, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
